// File: rtl/adc_sar_fsm_param.sv
// Purpose: SAR ADC sequencer with binary or redundant step search, per-channel offset trim and calibration.
// Latency: sample phase, then one SETTLE and one COMPARE phase per step, then one DONE cycle (adc_done strobe).
// Backpressure: COMPARE holds with clkout high until comp_valid; st_conv is ignored outside IDLE/SAMPLE.
//
// Ports:
//   clkin, rst          - clock (rising edge) and async active-low reset
//   st_conv             - rise starts sampling, fall starts the conversion
//   ch_sel/cal/sel_red  - channel, calibration request and search mode, latched on st_conv rise
//   comp_in/comp_valid  - comparator decision and its one-cycle strobe
//   step_we/addr/data   - redundant step-table write port (accepted only while idle)
//   clkout, sample      - comparator request, sample-and-hold enable
//   dac_value/msb/lsb   - current trial code and its split DAC drive (MSB half inverted)
//   result/_ch/_clip    - last conversion result, its channel and clamp flag
//   adc_done, busy      - completion strobe, conversion in progress
module adc_sar_fsm_param #(
    parameter int WIDTH    = 10,
    parameter int NSTEPS   = 12,
    parameter int NCH      = 4,
    parameter int LSB_BITS = WIDTH / 2,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW      = (NSTEPS > 1) ? $clog2(NSTEPS) : 1
) (
    input  logic                      clkin,
    input  logic                      rst,
    input  logic                      st_conv,
    input  logic [CHW-1:0]            ch_sel,
    input  logic                      cal,
    input  logic                      sel_red,
    input  logic                      comp_in,
    input  logic                      comp_valid,
    input  logic                      step_we,
    input  logic [AW-1:0]             step_addr,
    input  logic [WIDTH-1:0]          step_data,
    output logic                      clkout,
    output logic                      sample,
    output logic [WIDTH-1:0]          dac_value,
    output logic [WIDTH-LSB_BITS-1:0] dac_msb,
    output logic [LSB_BITS-1:0]       dac_lsb,
    output logic [WIDTH-1:0]          result,
    output logic [CHW-1:0]            result_ch,
    output logic                      result_clip,
    output logic                      adc_done,
    output logic                      busy
);

    localparam int ACC_W = WIDTH + 2;
    localparam int OFF_W = WIDTH + 1;

    typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, COMPARE, DONE} state_t;

    state_t                   state_q;
    logic                     stc_q;
    logic [CHW-1:0]           ch_q;
    logic                     cal_q;
    logic                     red_q;
    logic [AW-1:0]            ptr_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [WIDTH-1:0]         result_q;
    logic [CHW-1:0]           result_ch_q;
    logic                     clip_q;
    logic signed [OFF_W-1:0]  offset_q [NCH];
    logic [WIDTH-1:0]         table_q  [NSTEPS];
    logic                     sample_q;
    logic                     clkout_q;
    logic                     done_q;
    logic                     busy_q;

    logic                     st_rise;
    logic                     st_fall;
    logic [WIDTH-1:0]         step_d;
    logic signed [ACC_W-1:0]  acc_add_d;
    logic signed [ACC_W-1:0]  acc_new_d;
    logic signed [ACC_W-1:0]  acc_init_d;
    logic signed [ACC_W-1:0]  off_ext;
    logic [WIDTH-1:0]         clamp_d;
    logic                     clip_d;
    logic signed [OFF_W-1:0]  cal_off_d;

    assign st_rise = st_conv & ~stc_q;
    assign st_fall = ~st_conv & stc_q;

    always_comb begin
        step_d    = red_q ? table_q[ptr_q] : (WIDTH'(1) << ptr_q);
        // acc is wide enough that redundant over-range sums never wrap before the final clamp
        acc_add_d = acc_q + $signed({2'b00, step_d});
        acc_new_d = comp_in ? acc_add_d : acc_q;

        // negative -> 0; anything at or above 2^WIDTH -> all ones
        clamp_d = acc_new_d[WIDTH-1:0];
        clip_d  = 1'b0;
        if (acc_new_d[ACC_W-1]) begin
            clamp_d = '0;
            clip_d  = 1'b1;
        end else if (acc_new_d[WIDTH]) begin
            clamp_d = '1;
            clip_d  = 1'b1;
        end

        // a calibration converts a mid-scale input, so the error is acc minus mid-scale
        cal_off_d  = acc_new_d[OFF_W-1:0] - OFF_W'(2 ** (WIDTH - 1));

        off_ext    = ACC_W'(offset_q[ch_sel]);
        acc_init_d = cal ? '0 : -off_ext;
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            stc_q       <= 1'b0;
            ch_q        <= '0;
            cal_q       <= 1'b0;
            red_q       <= 1'b0;
            ptr_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            result_ch_q <= '0;
            clip_q      <= 1'b0;
            sample_q    <= 1'b0;
            clkout_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                offset_q[i] <= '0;
            end
            for (int i = 0; i < NSTEPS; i++) begin
                table_q[i] <= (i < WIDTH) ? WIDTH'(1) << i : WIDTH'(1);
            end
        end else begin
            stc_q  <= st_conv;
            done_q <= 1'b0;

            if (step_we && !busy_q) begin
                table_q[step_addr] <= step_data;
            end

            case (state_q)
                IDLE: begin
                    if (st_rise) begin
                        state_q  <= SAMPLE;
                        sample_q <= 1'b1;
                        busy_q   <= 1'b1;
                        ch_q     <= ch_sel;
                        cal_q    <= cal;
                        red_q    <= sel_red;
                        ptr_q    <= sel_red ? AW'(NSTEPS - 1) : AW'(WIDTH - 1);
                        acc_q    <= acc_init_d;
                    end
                end
                SAMPLE: begin
                    if (st_fall) begin
                        state_q  <= SETTLE;
                        sample_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    state_q  <= COMPARE;
                    clkout_q <= 1'b1;
                end
                COMPARE: begin
                    if (comp_valid) begin
                        clkout_q <= 1'b0;
                        acc_q    <= acc_new_d;
                        if (ptr_q == '0) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            result_q    <= clamp_d;
                            clip_q      <= clip_d;
                            result_ch_q <= ch_q;
                            if (cal_q) begin
                                offset_q[ch_q] <= cal_off_d;
                            end
                        end else begin
                            ptr_q   <= ptr_q - AW'(1);
                            state_q <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    sample_q <= 1'b0;
                    clkout_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dac_value   = acc_add_d[WIDTH-1:0];
    assign dac_msb     = ~dac_value[WIDTH-1:LSB_BITS];
    assign dac_lsb     = dac_value[LSB_BITS-1:0];
    assign clkout      = clkout_q;
    assign sample      = sample_q;
    assign result      = result_q;
    assign result_ch   = result_ch_q;
    assign result_clip = clip_q;
    assign adc_done    = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_adc_sar_fsm_param.sv
module tb_adc_sar_fsm_param;

    logic       clkin = 1'b0;
    logic       rst;
    logic       st_conv;
    logic [1:0] ch_sel;
    logic       cal;
    logic       sel_red;
    logic       comp_in;
    logic       comp_valid;
    logic       step_we;
    logic [3:0] step_addr;
    logic [9:0] step_data;
    logic       clkout;
    logic       sample;
    logic [9:0] dac_value;
    logic [4:0] dac_msb;
    logic [4:0] dac_lsb;
    logic [9:0] result;
    logic [1:0] result_ch;
    logic       result_clip;
    logic       adc_done;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    int tbl_vals [12] = '{1, 2, 2, 4, 7, 13, 21, 37, 65, 113, 246, 512};

    adc_sar_fsm_param dut (
        .clkin       (clkin),
        .rst         (rst),
        .st_conv     (st_conv),
        .ch_sel      (ch_sel),
        .cal         (cal),
        .sel_red     (sel_red),
        .comp_in     (comp_in),
        .comp_valid  (comp_valid),
        .step_we     (step_we),
        .step_addr   (step_addr),
        .step_data   (step_data),
        .clkout      (clkout),
        .sample      (sample),
        .dac_value   (dac_value),
        .dac_msb     (dac_msb),
        .dac_lsb     (dac_lsb),
        .result      (result),
        .result_ch   (result_ch),
        .result_clip (result_clip),
        .adc_done    (adc_done),
        .busy        (busy)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: comparator model (target >= dac), 1: forced 1, 2: forced 0
    task automatic run_conv(input int ch, input bit c, input bit red, input int mode,
                            input int target, output int res, output int clip,
                            output int rch, output int phases, output int dones,
                            output int samp);
        int  cyc;
        bit  fin;
        @(negedge clkin);
        ch_sel  = 2'(ch);
        cal     = c;
        sel_red = red;
        st_conv = 1'b1;
        repeat (3) @(negedge clkin);
        samp    = int'(sample);
        st_conv = 1'b0;
        phases  = 0;
        dones   = 0;
        fin     = 1'b0;
        cyc     = 0;
        while (!fin && cyc < 2000) begin
            @(negedge clkin);
            cyc++;
            if (adc_done) begin
                dones++;
                fin = 1'b1;
            end
            if (clkout && !comp_valid) begin
                comp_valid = 1'b1;
                case (mode)
                    0:       comp_in = (target >= int'(dac_value));
                    1:       comp_in = 1'b1;
                    default: comp_in = 1'b0;
                endcase
                phases++;
            end else begin
                comp_valid = 1'b0;
            end
        end
        comp_valid = 1'b0;
        if (!fin) check("conv_timeout", 0, 1);
        res  = int'(result);
        clip = int'(result_clip);
        rch  = int'(result_ch);
        repeat (3) begin
            @(negedge clkin);
            if (adc_done) dones++;
        end
        check("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        int res, clip, rch, phases, dones, samp;
        int lows, cyc;

        rst        = 1'b0;
        st_conv    = 1'b0;
        ch_sel     = '0;
        cal        = 1'b0;
        sel_red    = 1'b0;
        comp_in    = 1'b0;
        comp_valid = 1'b0;
        step_we    = 1'b0;
        step_addr  = '0;
        step_data  = '0;

        #1;
        check("rst_sample", int'(sample), 0);
        check("rst_clkout", int'(clkout), 0);
        check("rst_done", int'(adc_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_result", int'(result), 0);
        check("rst_clip", int'(result_clip), 0);
        repeat (2) @(negedge clkin);
        rst = 1'b1;

        // binary search, ch0, target 300
        run_conv(0, 1'b0, 1'b0, 0, 300, res, clip, rch, phases, dones, samp);
        check("bin_sample_hi", samp, 1);
        check("bin_phases", phases, 10);
        check("bin_result", res, 300);
        check("bin_clip", clip, 0);
        check("bin_ch", rch, 0);
        check("bin_done_cycles", dones, 1);

        // calibration on ch2: acc 515 -> offset +3
        run_conv(2, 1'b1, 1'b0, 0, 515, res, clip, rch, phases, dones, samp);
        check("cal_result", res, 515);
        check("cal_ch", rch, 2);
        run_conv(2, 1'b0, 1'b0, 1, 0, res, clip, rch, phases, dones, samp);
        check("ch2_ones_result", res, 1020);
        check("ch2_ones_clip", clip, 0);
        run_conv(1, 1'b0, 1'b0, 1, 0, res, clip, rch, phases, dones, samp);
        check("ch1_ones_result", res, 1023);
        check("ch1_ones_ch", rch, 1);
        run_conv(2, 1'b0, 1'b0, 2, 0, res, clip, rch, phases, dones, samp);
        check("ch2_zeros_result", res, 0);
        check("ch2_zeros_clip", clip, 1);

        // load redundant table and search for 700
        for (int a = 11; a >= 0; a--) begin
            @(negedge clkin);
            step_we   = 1'b1;
            step_addr = 4'(a);
            step_data = 10'(tbl_vals[a]);
        end
        @(negedge clkin);
        step_we = 1'b0;
        run_conv(0, 1'b0, 1'b1, 0, 700, res, clip, rch, phases, dones, samp);
        check("red_phases", phases, 12);
        check("red_result", res, 700);
        check("red_clip", clip, 0);
        check("red_done_cycles", dones, 1);

        // blocked table write, held COMPARE, ignored st_conv, reset mid-conversion
        @(negedge clkin);
        ch_sel  = 2'd0;
        cal     = 1'b0;
        sel_red = 1'b1;
        st_conv = 1'b1;
        repeat (2) @(negedge clkin);
        st_conv = 1'b0;
        cyc = 0;
        while (!clkout && cyc < 20) begin
            @(negedge clkin);
            cyc++;
        end
        check("hold_reach_compare", int'(clkout), 1);
        check("hold_dac_first", int'(dac_value), 512);
        check("hold_dac_msb", int'(dac_msb), 15);
        check("hold_dac_lsb", int'(dac_lsb), 0);
        step_we   = 1'b1;
        step_addr = 4'd11;
        step_data = 10'd0;
        @(negedge clkin);
        step_we = 1'b0;
        check("busy_write_dropped", int'(dac_value), 512);
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clkin);
            if (!clkout) lows++;
            if (i == 10) st_conv = 1'b1;
            if (i == 20) st_conv = 1'b0;
        end
        check("hold_clkout_lows", lows, 0);
        check("hold_busy", int'(busy), 1);
        check("hold_sample", int'(sample), 0);
        check("hold_dac_after", int'(dac_value), 512);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_clkout", int'(clkout), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(adc_done), 0);
        repeat (2) @(negedge clkin);
        rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clkin);
            if (adc_done || busy) dones++;
        end
        check("midrst_no_done", dones, 0);
        check("post_rst_result", int'(result), 0);
        check("post_rst_clip", int'(result_clip), 0);

        // reset table: sum is 1023 + 1 + 1 -> clamps high
        run_conv(3, 1'b0, 1'b1, 1, 0, res, clip, rch, phases, dones, samp);
        check("rst_table_result", res, 1023);
        check("rst_table_clip", clip, 1);
        check("rst_table_ch", rch, 3);
        // offsets cleared by reset
        run_conv(2, 1'b0, 1'b0, 1, 0, res, clip, rch, phases, dones, samp);
        check("rst_offset_result", res, 1023);
        run_conv(0, 1'b0, 1'b0, 0, 300, res, clip, rch, phases, dones, samp);
        check("post_rst_bin_result", res, 300);
        check("post_rst_bin_phases", phases, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_sar_fsm_param.md
ADC_SAR_FSM_PARAM -- requirements
Module: adc_sar_fsm_param

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the result and DAC code width (range 6..16).
REQ-002 The block SHALL have parameter NSTEPS, default 12, giving the redundant step-table depth (range WIDTH..2*WIDTH).
REQ-003 The block SHALL have parameter NCH, default 4, giving the channel count, each channel with its own offset register.
REQ-004 The block SHALL have parameter LSB_BITS, default WIDTH/2, giving the number of DAC code bits routed to the LSB array.

Ports (name  direction  width  meaning):
REQ-005 The ports SHALL be:
- clkin  in  1  single system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- st_conv  in  1  rise starts sampling, fall starts conversion.
- ch_sel  in  clog2(NCH)  channel, latched on st_conv rise.
- cal  in  1  calibration request, latched on st_conv rise.
- sel_red  in  1  1 = redundant table search, 0 = binary search; latched on st_conv rise.
- comp_in  in  1  comparator decision, 1 = add current step.
- comp_valid  in  1  one-cycle strobe, comp_in is valid.
- step_we  in  1  step-table write enable.
- step_addr  in  clog2(NSTEPS)  step-table write address.
- step_data  in  WIDTH  step-table write data.
- clkout  out  1  comparator request.
- sample  out  1  S&H switch enable, active high.
- dac_value  out  WIDTH  current trial code.
- dac_msb  out  WIDTH-LSB_BITS  bitwise inverse of dac_value[WIDTH-1:LSB_BITS].
- dac_lsb  out  LSB_BITS  dac_value[LSB_BITS-1:0].
- result  out  WIDTH  last conversion result.
- result_ch  out  clog2(NCH)  channel of result.
- result_clip  out  1  last result was clamped.
- adc_done  out  1  one-cycle completion strobe.
- busy  out  1  state != IDLE.

Function
REQ-006 The block SHALL implement states IDLE, SAMPLE, SETTLE, COMPARE and DONE.
REQ-007 In IDLE, a st_conv rise (registered 0->1) SHALL move the block to SAMPLE, latch ch_sel/cal/sel_red and load the pointer: binary mode ptr=WIDTH-1, redundant mode ptr=NSTEPS-1.
REQ-008 On the st_conv rise the accumulator (signed, WIDTH+2 bits) SHALL load 0 if cal=1, else -offset[ch].
REQ-009 sample SHALL be 1 exactly while in SAMPLE.
REQ-010 A st_conv fall (registered 1->0) SHALL move SAMPLE to SETTLE.
REQ-011 SETTLE SHALL last one cycle with clkout=0 and then go to COMPARE.
REQ-012 clkout SHALL be 1 exactly while in COMPARE; the block SHALL remain in COMPARE until comp_valid=1.
REQ-013 On comp_valid in COMPARE: if comp_in=1, acc += step(ptr); if ptr==0 go to DONE, else ptr-1 and go to SETTLE.
REQ-014 step(ptr) SHALL be 2^ptr in binary mode and table[ptr] in redundant mode.
REQ-015 dac_value SHALL equal (acc + step(ptr)) mod 2^WIDTH, combinationally.
REQ-016 On entry to DONE, result SHALL load acc clamped to [0, 2^WIDTH-1], result_clip SHALL be set when clamped, and result_ch SHALL load the latched channel.
REQ-017 adc_done SHALL be 1 for the single DONE cycle; DONE SHALL go to IDLE.
REQ-018 If cal was latched, the DONE entry SHALL also write offset[ch] = acc - 2^(WIDTH-1) (signed, WIDTH+1 bits); result SHALL still update.
REQ-019 st_conv edges outside IDLE/SAMPLE SHALL be ignored; a conversion SHALL NOT be aborted by st_conv.
REQ-020 comp_valid outside COMPARE SHALL be ignored.
REQ-021 step_we SHALL write the table only when busy=0; writes while busy SHALL be dropped.
REQ-022 In redundant mode, step sums exceeding the range SHALL be resolved only by the final clamp, with no intermediate wrap of acc.

Reset
REQ-023 rst low SHALL asynchronously force: state IDLE, ptr 0, acc 0, result 0, result_ch 0, result_clip 0, all offsets 0, registered st_conv 0, table[i] = 2^i for i<WIDTH and 1 for i>=WIDTH.
REQ-024 While rst is low, sample, clkout, adc_done and busy SHALL be 0.
REQ-025 Reset mid-conversion SHALL discard the conversion with no adc_done.

Verification
REQ-026 Binary mode, ch0, comparator model comp_in = (300 >= dac_value), WIDTH=10 -> 10 COMPARE phases, result=300, result_clip=0, adc_done one cycle.
REQ-027 cal=1 on ch2, model yields acc=515 -> offset[2]=+3; next ch2 conversion with comp_in forced 1 -> result=1020; ch1 conversion with comp_in forced 1 -> result=1023.
REQ-028 After REQ-027, ch2 conversion with comp_in forced 0 -> acc=-3, result=0, result_clip=1.
REQ-029 Table loaded with 512,246,113,65,37,21,13,7,4,2,2,1 (addr 11..0), sel_red=1, model target 700 -> 12 COMPARE phases, result=700.
REQ-030 step_we during COMPARE -> table unchanged; rst low during COMPARE -> clkout=0 immediately, no adc_done, st_conv rise after release starts a new conversion.
REQ-031 comp_valid held low for 50 cycles in COMPARE -> clkout stays 1 and the state is held; st_conv toggled while busy has no effect.
